// File: rtl/sequence_game_ctrl.sv
// sequence_game_ctrl
// Controller for a Simon-style "repeat the sequence" game. Each round it
// appends one pseudo-random 2-bit symbol to an external 2**ADDR_W x 2-bit
// memory, plays the stored sequence back on show_*, then checks the
// player's presses against memory. The game is won after 2**ADDR_W rounds.
//
// Optional build macro: TIMEOUT_EN
//   When defined, each INPUT wait is bounded to TIMEOUT_CYCLES cycles. Running
//   out of time without a press loses the game. When undefined, INPUT waits
//   forever and TIMEOUT_CYCLES is not used.
//
// Ports:
//   clk, rst        clock (rising edge), async active-high reset
//   start           one-cycle pulse, begins a new game (ignored while busy)
//   btn_valid       one-cycle pulse, player pressed a button
//   btn_value       symbol of the pressed button
//   mem_value_out   memory read data, one cycle after mem_addr
//   mem_write_en    memory write strobe (combinational)
//   mem_addr        memory address (combinational)
//   mem_value_in    memory write data (combinational)
//   show_valid      registered, a sequence symbol is on show_value
//   show_value      registered, symbol being displayed
//   level           registered, current sequence length 0..2**ADDR_W
//   busy            registered, high outside IDLE/WIN/LOSE
//   win, lose       registered, held high in WIN / LOSE
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | after reset, waiting for start
// GEN      | write one new random symbol at address level
// SHOW_RD  | present idx to memory
// SHOW_CAP | capture read data into show_value, load hold timer
// SHOW     | display symbol until the hold timer expires
// INPUT    | wait for the player's press for entry idx
// CMP      | compare latched press with memory entry idx
// WIN      | all rounds completed, waiting for start
// LOSE     | wrong press (or timeout), waiting for start

module sequence_game_ctrl #(
    parameter int          ADDR_W         = 2,
    parameter int          SHOW_CYCLES    = 4,
    parameter logic [7:0]  LFSR_SEED      = 8'hA5,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              btn_valid,
    input  logic [1:0]        btn_value,
    input  logic [1:0]        mem_value_out,
    output logic              mem_write_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [1:0]        mem_value_in,
    output logic              show_valid,
    output logic [1:0]        show_value,
    output logic [ADDR_W:0]   level,
    output logic              busy,
    output logic              win,
    output logic              lose
);

    localparam int TMAX    = (SHOW_CYCLES > TIMEOUT_CYCLES) ? SHOW_CYCLES : TIMEOUT_CYCLES;
    localparam int TIMER_W = $clog2(TMAX + 1);
    localparam logic [TIMER_W-1:0] SHOW_LOAD = TIMER_W'(SHOW_CYCLES - 1);
    localparam logic [ADDR_W:0]    DEPTH_L   = (ADDR_W + 1)'(2 ** ADDR_W);
`ifdef TIMEOUT_EN
    localparam logic [TIMER_W-1:0] TO_LOAD   = TIMER_W'(TIMEOUT_CYCLES - 1);
`endif

    typedef enum logic [3:0] {
        S_IDLE, S_GEN, S_SHOW_RD, S_SHOW_CAP, S_SHOW, S_INPUT, S_CMP, S_WIN, S_LOSE
    } state_t;

    state_t             state, state_n;
    logic [7:0]         lfsr;
    logic [ADDR_W-1:0]  idx, idx_n;
    logic [ADDR_W:0]    level_n;
    logic [TIMER_W-1:0] timer, timer_n;
    logic [1:0]         btn_q, btn_n;
    logic               show_valid_n;
    logic [1:0]         show_value_n;
    logic               last;

    // idx is the final entry of the current sequence
    assign last = ({1'b0, idx} == (level - 1'b1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            lfsr       <= LFSR_SEED;
            level      <= '0;
            idx        <= '0;
            timer      <= '0;
            btn_q      <= '0;
            show_valid <= 1'b0;
            show_value <= '0;
            busy       <= 1'b0;
            win        <= 1'b0;
            lose       <= 1'b0;
        end else begin
            state      <= state_n;
            // x^8+x^6+x^5+x^4+1, free-running in every state
            lfsr       <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            level      <= level_n;
            idx        <= idx_n;
            timer      <= timer_n;
            btn_q      <= btn_n;
            show_valid <= show_valid_n;
            show_value <= show_value_n;
            // flags follow the next state so they line up with the state register
            busy       <= !(state_n inside {S_IDLE, S_WIN, S_LOSE});
            win        <= (state_n == S_WIN);
            lose       <= (state_n == S_LOSE);
        end
    end

    always_comb begin
        state_n      = state;
        level_n      = level;
        idx_n        = idx;
        timer_n      = timer;
        btn_n        = btn_q;
        show_valid_n = show_valid;
        show_value_n = show_value;
        mem_write_en = 1'b0;
        mem_addr     = idx;
        mem_value_in = 2'b00;

        case (state)
            S_IDLE, S_WIN, S_LOSE: begin
                if (start) begin
                    level_n = '0;
                    state_n = S_GEN;
                end
            end
            S_GEN: begin
                mem_write_en = 1'b1;
                mem_addr     = level[ADDR_W-1:0];
                mem_value_in = lfsr[1:0];
                level_n      = level + 1'b1;
                idx_n        = '0;
                state_n      = S_SHOW_RD;
            end
            S_SHOW_RD: begin
                state_n = S_SHOW_CAP;
            end
            S_SHOW_CAP: begin
                show_value_n = mem_value_out;
                show_valid_n = 1'b1;
                timer_n      = SHOW_LOAD;
                state_n      = S_SHOW;
            end
            S_SHOW: begin
                if (timer == '0) begin
                    show_valid_n = 1'b0;
                    if (last) begin
                        idx_n   = '0;
                        state_n = S_INPUT;
`ifdef TIMEOUT_EN
                        timer_n = TO_LOAD;
`endif
                    end else begin
                        idx_n   = idx + 1'b1;
                        state_n = S_SHOW_RD;
                    end
                end else begin
                    timer_n = timer - 1'b1;
                end
            end
            S_INPUT: begin
                // a press on the final timeout cycle still counts
                if (btn_valid) begin
                    btn_n   = btn_value;
                    state_n = S_CMP;
                end
`ifdef TIMEOUT_EN
                else if (timer == '0) begin
                    state_n = S_LOSE;
                end else begin
                    timer_n = timer - 1'b1;
                end
`endif
            end
            S_CMP: begin
                if (mem_value_out != btn_q) begin
                    state_n = S_LOSE;
                end else if (!last) begin
                    idx_n   = idx + 1'b1;
                    state_n = S_INPUT;
`ifdef TIMEOUT_EN
                    timer_n = TO_LOAD;
`endif
                end else if (level == DEPTH_L) begin
                    state_n = S_WIN;
                end else begin
                    state_n = S_GEN;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_sequence_game_ctrl.sv
module tb_sequence_game_ctrl;
    localparam int ADDR_W         = 2;
    localparam int DEPTH          = 4;
    localparam int SHOW_CYCLES    = 2;
    localparam int TIMEOUT_CYCLES = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              btn_valid = 1'b0;
    logic [1:0]        btn_value = 2'b00;
    logic [1:0]        mem_value_out = 2'b00;
    logic              mem_write_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [1:0]        mem_value_in;
    logic              show_valid;
    logic [1:0]        show_value;
    logic [ADDR_W:0]   level;
    logic              busy, win, lose;

    sequence_game_ctrl #(
        .ADDR_W(ADDR_W), .SHOW_CYCLES(SHOW_CYCLES),
        .LFSR_SEED(8'hA5), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .btn_valid(btn_valid),
        .btn_value(btn_value), .mem_value_out(mem_value_out),
        .mem_write_en(mem_write_en), .mem_addr(mem_addr), .mem_value_in(mem_value_in),
        .show_valid(show_valid), .show_value(show_value), .level(level),
        .busy(busy), .win(win), .lose(lose)
    );

    always #5 clk = ~clk;

    // external memory: registered read, one cycle latency
    logic [1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (mem_write_en) mem[mem_addr] <= mem_value_in;
        mem_value_out <= mem[mem_addr];
    end

    // reference symbol source: the LFSR as the rules define it
    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction
    logic [7:0] ref_lfsr;
    always @(posedge clk or posedge rst) begin
        if (rst) ref_lfsr <= 8'hA5;
        else     ref_lfsr <= lfsr_next(ref_lfsr);
    end

    int checks = 0;
    int passed = 0;
    int shown_total = 0;
    logic [1:0] seq[$];        // the game's sequence according to the model
    logic [1:0] exp_show[$];   // symbols expected on the display, in order
    logic [4:0] exp_out[$];    // {lose, win, level} expected at each game end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic fail(input string name, input string what);
        checks++;
        $display("FAIL %s: %s at %0t", name, what, $time);
    endtask

    // monitor / scoreboard
    initial begin
        logic prev_sv, prev_win, prev_lose;
        int run;
        prev_sv = 0; prev_win = 0; prev_lose = 0; run = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_sv = 0; prev_win = 0; prev_lose = 0; run = 0;
                continue;
            end
            if (mem_write_en) begin
                check("wr_addr", 32'(mem_addr), 32'(seq.size()));
                check("wr_sym", 32'(mem_value_in), 32'(ref_lfsr[1:0]));
                check("gen_level", 32'(level), 32'(seq.size()));
                seq.push_back(ref_lfsr[1:0]);
                foreach (seq[i]) exp_show.push_back(seq[i]);
            end
            if (show_valid && !prev_sv) begin
                shown_total++;
                if (exp_show.size() == 0)
                    fail("show_unexpected", $sformatf("got symbol %0d with none expected", show_value));
                else
                    check("show_sym", 32'(show_value), 32'(exp_show.pop_front()));
                run = 1;
            end else if (show_valid) begin
                run++;
            end else if (prev_sv) begin
                check("show_len", 32'(run), 32'(SHOW_CYCLES));
            end
            if ((win && !prev_win) || (lose && !prev_lose)) begin
                if (exp_out.size() == 0)
                    fail("outcome_unexpected", $sformatf("got lose=%0b win=%0b level=%0d with none expected", lose, win, level));
                else
                    check("outcome", 32'({lose, win, level}), 32'(exp_out.pop_front()));
            end
            prev_sv = show_valid; prev_win = win; prev_lose = lose;
        end
    end

    // wait until the show of the current round is done; returns at the first INPUT cycle
    task automatic wait_shows(input int target, input bit noise, output bit ok);
        ok = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk); #1;
            if (shown_total >= target && !show_valid) begin
                btn_valid = 0;
                ok = 1;
                return;
            end
            if (noise) begin
                btn_valid = 1'($urandom_range(0, 1));
                btn_value = 2'($urandom);
            end
        end
        btn_valid = 0;
        fail("show_wait", $sformatf("shown %0d of %0d symbols before cycle budget ran out", shown_total, target));
    endtask

    // called in an INPUT cycle; returns in the CMP cycle
    task automatic press(input logic [1:0] v, input int delay);
        btn_valid = 0;
        for (int d = 0; d < delay; d++) begin
            start = 1'($urandom_range(0, 1));
            @(negedge clk); #1;
        end
        btn_valid = 1; btn_value = v; start = 1'($urandom_range(0, 1));
        @(negedge clk); #1;
        start = 0;
        // second press during CMP must be dropped
        btn_valid = 1'($urandom_range(0, 1));
        btn_value = 2'($urandom);
    endtask

    task automatic start_game(output int base);
        seq.delete(); exp_show.delete();
        start = 1; base = shown_total;
        @(negedge clk); #1;
        start = 0;
        check("start_flags", 32'({win, lose, busy}), 32'(3'b001));
        @(negedge clk); #1;
        check("start_level", 32'(level), 32'd1);
    endtask

    task automatic play_game(input int wrong_round, input int first_delay);
        int base, d;
        bit ok;
        logic [1:0] v;
        start_game(base);
        for (int r = 1; r <= DEPTH; r++) begin
            wait_shows(base + r, 1'b1, ok);
            if (!ok) return;
            for (int i = 0; i < r; i++) begin
                if (i > 0) begin @(negedge clk); #1; end
                v = seq[i];
                d = (r == 1 && i == 0 && first_delay >= 0) ? first_delay : int'($urandom_range(0, 3));
                if (r == wrong_round && i == 1) begin
                    v = v + 2'd1;
                    exp_out.push_back({1'b1, 1'b0, 3'(r)});
                    press(v, d);
                    btn_valid = 0;
                    check("lose_early", 32'(lose), 32'd0);
                    @(negedge clk); #1;
                    check("lose_2cyc", 32'({lose, busy, level}), 32'({1'b1, 1'b0, 3'(r)}));
                    return;
                end
                if (r == DEPTH && i == r - 1) exp_out.push_back({1'b0, 1'b1, 3'(DEPTH)});
                press(v, d);
            end
            base = shown_total;
        end
        btn_valid = 0;
        @(negedge clk); #1;
        check("win_state", 32'({win, lose, busy, level}), 32'({1'b1, 1'b0, 1'b0, 3'(DEPTH)}));
        repeat (3) @(negedge clk);
        #1;
        check("win_held", 32'({win, lose, busy, level, show_valid}), 32'({1'b1, 1'b0, 1'b0, 3'(DEPTH), 1'b0}));
    endtask

    initial begin
        int base;
        bit ok;
        repeat (3) @(negedge clk);
        #1;
        check("reset_outs", 32'({show_valid, show_value, level, busy, win, lose, mem_write_en}), 32'd0);
        rst = 0;

        // full game with noise on btn_valid during show and start during input
        play_game(0, -1);
        // wrong press in round 2, then a fresh game from LOSE with a slow first press
        play_game(2, -1);
        play_game(0, 7);

        // reset in the middle of a show
        start_game(base);
        ok = 0;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge clk);
            ok = show_valid;
        end
        if (!ok) fail("rst_wait", "show_valid never rose");
        repeat ($urandom_range(0, 1)) @(posedge clk);
        @(posedge clk);
        #($urandom_range(1, 8));
        rst = 1;
        #1;
        check("rst_mid_outs", 32'({show_valid, show_value, level, busy, win, lose, mem_write_en, mem_addr}), 32'd0);
        seq.delete(); exp_show.delete();
        @(negedge clk); #1;
        rst = 0;
        play_game(0, -1);

`ifdef TIMEOUT_EN
        // no press at all in round 1
        start_game(base);
        wait_shows(base + 1, 1'b0, ok);
        if (ok) begin
            exp_out.push_back({1'b1, 1'b0, 3'd1});
            repeat (TIMEOUT_CYCLES - 1) @(negedge clk);
            #1;
            check("timeout_early", 32'(lose), 32'd0);
            @(negedge clk); #1;
            check("timeout_lose", 32'({lose, busy}), 32'({1'b1, 1'b0}));
        end
`endif

        repeat (5) @(negedge clk);
        #1;
        check("show_queue_empty", 32'(exp_show.size()), 32'd0);
        check("outcome_queue_empty", 32'(exp_out.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    // overall guard so the run cannot hang
    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not complete, %0d checks done", checks);
        $fatal(1);
    end

endmodule
